// File: rtl/core_result_collector_if.sv
// Result-return bus between the MatrixCore result ports and the host-side stream.
interface core_result_collector_if #(
    parameter int unsigned DATA_SIZE   = 16,
    parameter int unsigned COLUMN_SIZE = 16,
    parameter int unsigned ROW_SIZE    = 16,
    parameter int unsigned Cores       = 4,
    parameter int unsigned FIFO_DEPTH  = 4
);
    localparam int unsigned CW   = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int unsigned RW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int unsigned IW   = (Cores > 1) ? $clog2(Cores) : 1;
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

    // Core side (fan-in)
    logic [Cores-1:0]           core_valid;
    logic [Cores-1:0]           core_ready;
    logic [Cores*DATA_SIZE-1:0] core_data;
    logic [Cores*RW-1:0]        core_row;
    logic [Cores*CW-1:0]        core_col;

    // Host side (ordered stream)
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_SIZE-1:0]       out_data;
    logic [RW-1:0]              out_row;
    logic [CW-1:0]              out_col;
    logic [IW-1:0]              out_core;

    // Status
    logic [CNTW-1:0]            fifo_count;
    logic [15:0]                total_accepted;

    // Environment view: drives core results and host back-pressure
    modport master (
        output core_valid, core_data, core_row, core_col, out_ready,
        input  core_ready, out_valid, out_data, out_row, out_col, out_core,
               fifo_count, total_accepted
    );

    // Collector view
    modport slave (
        input  core_valid, core_data, core_row, core_col, out_ready,
        output core_ready, out_valid, out_data, out_row, out_col, out_core,
               fifo_count, total_accepted
    );
endinterface

// File: rtl/core_result_collector.sv
// Round-robin fan-in of MatrixCore result words into one ordered FIFO-backed stream.
module core_result_collector #(
    parameter int unsigned DATA_SIZE   = 16,
    parameter int unsigned COLUMN_SIZE = 16,
    parameter int unsigned ROW_SIZE    = 16,
    parameter int unsigned Cores       = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst,
    core_result_collector_if.slave bus
);
    localparam int unsigned CW   = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int unsigned RW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int unsigned IW   = (Cores > 1) ? $clog2(Cores) : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [RW-1:0]        row;
        logic [CW-1:0]        col;
        logic [IW-1:0]        core;
    } entry_t;

    // Per-core views of the flattened result buses
    logic [DATA_SIZE-1:0] data_arr [Cores];
    logic [RW-1:0]        row_arr  [Cores];
    logic [CW-1:0]        col_arr  [Cores];

    for (genvar i = 0; i < Cores; i++) begin : g_unpack
        assign data_arr[i] = bus.core_data[i*DATA_SIZE +: DATA_SIZE];
        assign row_arr[i]  = bus.core_row[i*RW +: RW];
        assign col_arr[i]  = bus.core_col[i*CW +: CW];
    end

    // State
    entry_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [IW-1:0]   rr_ptr;
    logic [15:0]     total;

    // Arbiter / handshake decode
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   rr_next;
    logic            not_full;
    logic            push;
    logic            pop;
    logic [Cores-1:0] ready_vec;
    entry_t          new_entry;
    entry_t          head;

    // Round-robin scan starting at rr_ptr; first valid core wins
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < Cores; k++) begin
            idx = (32'(rr_ptr) + k) % Cores;
            if (!grant_found && bus.core_valid[IW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    // Priority moves to the core just after the one served
    always_comb begin
        rr_next = (grant_idx == IW'(Cores - 1)) ? '0 : grant_idx + IW'(1);
    end

    // Acceptance looks only at occupancy, never at out_ready, so a full FIFO
    // stalls the cores even in a cycle where the head is being drained
    always_comb begin
        not_full  = (count < CNTW'(FIFO_DEPTH));
        push      = grant_found && not_full && !rst;
        pop       = (count != '0) && bus.out_ready;
        ready_vec = '0;
        if (push) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Payload captured from the granted core
    always_comb begin
        new_entry.data = data_arr[grant_idx];
        new_entry.row  = row_arr[grant_idx];
        new_entry.col  = col_arr[grant_idx];
        new_entry.core = grant_idx;
    end

    // FIFO storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Write/read pointers wrap naturally on the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Round-robin pointer advances only when a result is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= rr_next;
        end
    end

    // Running count of accepted results, wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total <= '0;
        end else if (push) begin
            total <= total + 16'd1;
        end
    end

    // Head of the FIFO drives the host-side stream
    always_comb begin
        head = mem[rd_ptr];
    end

    assign bus.core_ready     = ready_vec;
    assign bus.out_valid      = (count != '0);
    assign bus.out_data       = head.data;
    assign bus.out_row        = head.row;
    assign bus.out_col        = head.col;
    assign bus.out_core       = head.core;
    assign bus.fifo_count     = count;
    assign bus.total_accepted = total;

endmodule

// File: tb/tb_core_result_collector.sv
// Self-checking bench for core_result_collector: directed table, corner sequences, random vs queue model.
module tb_core_result_collector;
    localparam int unsigned NC    = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    core_result_collector_if bus ();

    core_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Source-side state: each core holds its result until accepted
    logic        pend [NC];
    logic [15:0] sd   [NC];
    logic [3:0]  sr   [NC];
    logic [3:0]  sc   [NC];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  row;
        logic [3:0]  col;
        logic [1:0]  core;
    } ent_t;

    typedef struct {
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_core;
        logic [2:0]  exp_cnt;
        logic [15:0] exp_total;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_data();
        bus.core_data = {sd[3], sd[2], sd[1], sd[0]};
        bus.core_row  = {sr[3], sr[2], sr[1], sr[0]};
        bus.core_col  = {sc[3], sc[2], sc[1], sc[0]};
    endtask

    task automatic drive_pending();
        bus.core_valid = {pend[3], pend[2], pend[1], pend[0]};
        drive_data();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.core_valid = '0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_fixed_data();
        logic [1:0] j;
        for (int i = 0; i < 4; i++) begin
            j = 2'(i);
            sd[j] = 16'h00C0 + 16'(j);
            sr[j] = 4'(j);
            sc[j] = 4'(j) + 4'd8;
        end
        drive_data();
    endtask

    initial begin
        ent_t        q[$];
        ent_t        e;
        logic [1:0]  m_rr;
        logic [15:0] m_total;
        logic        found;
        logic [1:0]  g;
        logic [1:0]  j;
        logic [3:0]  exp_ready;
        int          ordy_thresh;

        //                 valid ordy ready ov   core  cnt   total
        tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 3'd0, 16'd0};
        tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b1, 2'd0, 3'd1, 16'd1};
        tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b1, 2'd0, 3'd2, 16'd2};
        tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b1, 2'd0, 3'd3, 16'd3};
        tbl[4]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 3'd4, 16'd4};
        tbl[5]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 3'd4, 16'd4};
        tbl[6]  = '{4'hF, 1'b0, 4'h1, 1'b1, 2'd1, 3'd3, 16'd4};
        tbl[7]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 3'd4, 16'd5};
        tbl[8]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd2, 3'd3, 16'd5};
        tbl[9]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 3'd3, 16'd6};
        tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 3'd2, 16'd6};
        tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 3'd1, 16'd6};
        tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0, 16'd6};
        tbl[13] = '{4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 3'd0, 16'd6};
        tbl[14] = '{4'h1, 1'b0, 4'h1, 1'b1, 2'd2, 3'd1, 16'd7};
        tbl[15] = '{4'h2, 1'b1, 4'h2, 1'b1, 2'd2, 3'd2, 16'd8};
        tbl[16] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 3'd2, 16'd9};
        tbl[17] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 3'd1, 16'd9};
        tbl[18] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0, 16'd9};

        for (int i = 0; i < 4; i++) begin
            j = 2'(i);
            pend[j] = 1'b0;
            sd[j] = '0;
            sr[j] = '0;
            sc[j] = '0;
        end
        rst = 1'b1;
        bus.core_valid = 4'hF;
        bus.out_ready  = 1'b1;
        drive_data();

        // Reset holds everything idle even with all cores requesting
        repeat (2) @(negedge clk);
        #1;
        check("rst_core_ready", 32'(bus.core_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
        check("rst_total", 32'(bus.total_accepted), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_core", 32'(bus.out_core), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.core_valid = '0;

        // Single core, one-cycle latency to the output
        @(negedge clk);
        sd[2] = 16'h00A5; sr[2] = 4'd3; sc[2] = 4'd7;
        drive_data();
        bus.core_valid = 4'b0100;
        bus.out_ready  = 1'b1;
        #1;
        check("single_ready", 32'(bus.core_ready), 32'h4);
        @(negedge clk);
        bus.core_valid = '0;
        #1;
        check("single_ready_after", 32'(bus.core_ready), 32'h0);
        check("single_ov", 32'(bus.out_valid), 32'h1);
        check("single_data", 32'(bus.out_data), 32'h00A5);
        check("single_row", 32'(bus.out_row), 32'd3);
        check("single_col", 32'(bus.out_col), 32'd7);
        check("single_core", 32'(bus.out_core), 32'd2);
        @(negedge clk);
        #1;
        check("single_drained", 32'(bus.out_valid), 32'h0);

        // Round-robin rotation with all cores requesting
        do_reset();
        set_fixed_data();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.core_valid = 4'hF;
            bus.out_ready  = 1'b1;
            #1;
            check("rr_ready", 32'(bus.core_ready), 32'(4'b0001 << (c % 4)));
            if (c > 0) begin
                check("rr_head_core", 32'(bus.out_core), 32'((c - 1) % 4));
                check("rr_count", 32'(bus.fifo_count), 32'd1);
            end
        end
        @(negedge clk);
        bus.core_valid = '0;
        #1;
        check("rr_total", 32'(bus.total_accepted), 32'd5);

        // Directed table: back-pressure, full stall, push+pop, drain
        do_reset();
        set_fixed_data();
        for (int s = 0; s < 19; s++) begin
            @(negedge clk);
            bus.core_valid = tbl[s].valid;
            bus.out_ready  = tbl[s].ordy;
            #1;
            check($sformatf("tbl%0d_ready", s), 32'(bus.core_ready), 32'(tbl[s].exp_ready));
            check($sformatf("tbl%0d_ov", s), 32'(bus.out_valid), 32'(tbl[s].exp_ov));
            check($sformatf("tbl%0d_count", s), 32'(bus.fifo_count), 32'(tbl[s].exp_cnt));
            check($sformatf("tbl%0d_total", s), 32'(bus.total_accepted), 32'(tbl[s].exp_total));
            if (tbl[s].exp_ov) begin
                check($sformatf("tbl%0d_core", s), 32'(bus.out_core), 32'(tbl[s].exp_core));
                check($sformatf("tbl%0d_data", s), 32'(bus.out_data), 32'(16'h00C0 + 16'(tbl[s].exp_core)));
                check($sformatf("tbl%0d_row", s), 32'(bus.out_row), 32'(tbl[s].exp_core));
                check($sformatf("tbl%0d_col", s), 32'(bus.out_col), 32'(4'(tbl[s].exp_core) + 4'd8));
            end
        end

        // Mid-operation reset discards buffered results asynchronously
        do_reset();
        set_fixed_data();
        @(negedge clk);
        bus.core_valid = 4'hF;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        bus.core_valid = '0;
        #1;
        check("mid_count_before", 32'(bus.fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ov_async", 32'(bus.out_valid), 32'h0);
        check("mid_count_async", 32'(bus.fifo_count), 32'h0);
        check("mid_total_async", 32'(bus.total_accepted), 32'h0);
        check("mid_ready_async", 32'(bus.core_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.core_valid = 4'b1100;
        bus.out_ready  = 1'b1;
        #1;
        check("mid_first_ready", 32'(bus.core_ready), 32'h4);
        @(negedge clk);
        bus.core_valid = '0;
        #1;
        check("mid_first_ov", 32'(bus.out_valid), 32'h1);
        check("mid_first_core", 32'(bus.out_core), 32'd2);

        // Random traffic against a queue-based reference model
        do_reset();
        q.delete();
        m_rr = '0;
        m_total = '0;
        for (int i = 0; i < 4; i++) begin
            j = 2'(i);
            pend[j] = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            ordy_thresh = ((cyc / 200) % 2 == 0) ? 8 : 3;
            for (int i = 0; i < 4; i++) begin
                j = 2'(i);
                if (!pend[j] && ($urandom_range(0, 1) == 1)) begin
                    pend[j] = 1'b1;
                    sd[j] = 16'($urandom);
                    sr[j] = 4'($urandom);
                    sc[j] = 4'($urandom);
                end
            end
            bus.out_ready = ($urandom_range(0, 9) < ordy_thresh);
            drive_pending();
            #1;
            found = 1'b0;
            g = '0;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < 4; k++) begin
                    j = m_rr + 2'(k);
                    if (!found && pend[j]) begin
                        found = 1'b1;
                        g = j;
                    end
                end
            end
            exp_ready = found ? (4'b0001 << g) : 4'b0000;
            check("rnd_ready", 32'(bus.core_ready), 32'(exp_ready));
            check("rnd_ov", 32'(bus.out_valid), 32'(q.size() != 0));
            check("rnd_count", 32'(bus.fifo_count), 32'(q.size()));
            check("rnd_total", 32'(bus.total_accepted), 32'(m_total));
            if (q.size() != 0) begin
                check("rnd_data", 32'(bus.out_data), 32'(q[0].data));
                check("rnd_row", 32'(bus.out_row), 32'(q[0].row));
                check("rnd_col", 32'(bus.out_col), 32'(q[0].col));
                check("rnd_core", 32'(bus.out_core), 32'(q[0].core));
            end
            if (q.size() != 0 && bus.out_ready) begin
                void'(q.pop_front());
            end
            if (found) begin
                e.data = sd[g];
                e.row  = sr[g];
                e.col  = sc[g];
                e.core = g;
                q.push_back(e);
                m_rr = g + 2'd1;
                m_total = m_total + 16'd1;
                pend[g] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_result_collector.md
# core_result_collector

Gathers result words produced by the MatrixCore instances inside the processing socket and merges them into one ordered output stream for the host side. It is the return path that complements the instruction decoder: the decoder fans commands out to the cores, and this block fans their results back in. It uses a round-robin arbiter in front of a small FIFO, with valid/ready handshakes on both sides.

## Interface
- DATA_SIZE, 16, width of one result element
- COLUMN_SIZE, 16, matrix columns; CW = $clog2(COLUMN_SIZE)
- ROW_SIZE, 16, matrix rows; RW = $clog2(ROW_SIZE)
- Cores, 4, number of core result ports; IW = $clog2(Cores), minimum 1
- FIFO_DEPTH, 4, entries; power of two, minimum 2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- core_valid  in  Cores  bit i: core i presents a result
- core_ready  out  Cores  bit i: core i's result is accepted this cycle
- core_data  in  Cores*DATA_SIZE  slice i = core i's element
- core_row  in  Cores*RW  slice i = row index of the element
- core_col  in  Cores*CW  slice i = column index of the element
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  DATA_SIZE  head element
- out_row  out  RW  head row index
- out_col  out  CW  head column index
- out_core  out  IW  source core of head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- total_accepted  out  16  count of accepted results, wraps at 65535 -> 0

## Operation
- Arbiter: rr_ptr (IW bits) holds the highest-priority core. The grant goes to the first i with core_valid[i] set, scanning rr_ptr, rr_ptr+1, … mod Cores.
- core_ready is combinational. It is one-hot on the granted core when fifo_count < FIFO_DEPTH and rst is low; otherwise it is all zero. It never depends on out_ready, so there is no combinational path from out_ready to core_ready.
- A push occurs when core_valid[g] & core_ready[g]. It writes {data, row, col, g} at wr_ptr, advances wr_ptr mod FIFO_DEPTH, sets rr_ptr to (g+1) mod Cores, and increments total_accepted.
- With no push, rr_ptr holds.
- A pop occurs when out_valid & out_ready. It advances rd_ptr mod FIFO_DEPTH.
- out_* reflect the entry at rd_ptr. out_valid = (fifo_count != 0).
- fifo_count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, or on neither
- Full (count == FIFO_DEPTH): core_ready is 0 even if a pop happens in the same cycle. Acceptance resumes the cycle after the pop.
- Empty: out_valid = 0, and out_ready is ignored.
- Once a core presents core_valid, it must hold valid and data stable until accepted. The collector does not check this.
- Slice widths and the row/col fields pass through unmodified. No arithmetic is performed on data.

## Timing
- Reset (async assert, sync-safe deassert): rr_ptr, wr_ptr, rd_ptr, fifo_count, total_accepted = 0; all FIFO storage = 0.
- Output values during and after reset: out_valid = 0, out_data = out_row = out_col = out_core = 0, core_ready = 0.
- Latency: a result accepted on edge N is visible on out_* with out_valid = 1 after edge N (one cycle), when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Back-pressure: with out_ready held low, exactly FIFO_DEPTH results are accepted, then core_ready stays 0.
- rst asserted mid-transfer: in-flight and buffered results are discarded. The first cycle after deassert behaves as after power-up.
- Fairness: with all cores continuously valid and the FIFO never full, grants rotate 0,1,2,3,0,… and each core is served once every Cores cycles.

## Test plan
- Reset: assert rst with core_valid = 4'b1111 → core_ready = 0, out_valid = 0, fifo_count = 0, total_accepted = 0 while rst is high.
- Single core: core 2 presents data 16'h00A5, row 3, col 7; out_ready = 1 → core_ready = 4'b0100 for one cycle. Next cycle out_valid = 1, out_data = 16'h00A5, out_row = 3, out_col = 7, out_core = 2.
- Round-robin: all four cores valid continuously, out_ready = 1 → grant order 0,1,2,3,0 on consecutive cycles; total_accepted = 5 after five cycles.
- Full/back-pressure: out_ready = 0, all cores valid → four pushes (cores 0–3), fifo_count = 4, core_ready = 0. Raise out_ready for one cycle → pop of the core-0 entry, no push that cycle, push resumes the next cycle with core 0 granted.
- Simultaneous push/pop at count 2 → fifo_count stays 2; the output order matches acceptance order.
- Mid-operation reset with fifo_count = 3 → out_valid drops immediately (async), and all counters = 0. After release, the first accepted result emerges with out_core equal to the lowest valid core index.
